// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared widths, RISC-V major opcodes and ALU operation
// encodings for the ALU arbiter and its operand selector.
//   XLEN_DEF  default datapath width
//   OPW_DEF   default ALU operation select width
//   OPC_W     RISC-V major opcode width
package alu_arbiter_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned OPW_DEF  = 4;
    localparam int unsigned OPC_W    = 7;

    // Major opcodes that route real operands to the ALU
    localparam logic [OPC_W-1:0] RISCV_AUIPC       = 7'b0010111;
    localparam logic [OPC_W-1:0] RISCV_ALU_OP_REGS = 7'b0110011;
    localparam logic [OPC_W-1:0] RISCV_ALU_OP_IMM  = 7'b0010011;

    // ALU operation encodings driven on alu_op
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu_operand_select.sv
// alu_operand_select: picks the two ALU operands from an instruction's fields
// according to its RISC-V major opcode. Purely combinational.
//   opcode_i          major opcode
//   rs1_i, rs2_i      register operands
//   pc_i, imm_i       instruction pc and sign-extended immediate
//   in1_c_o, in2_c_o  selected ALU operands (zero for non-ALU opcodes)
module alu_operand_select
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    output logic [XLEN-1:0]  in1_c_o,
    output logic [XLEN-1:0]  in2_c_o
);

    // Opcode-driven operand mux
    always_comb begin
        in1_c_o = '0;
        in2_c_o = '0;
        case (opcode_i)
            RISCV_AUIPC: begin
                in1_c_o = pc_i;
                in2_c_o = imm_i;
            end
            RISCV_ALU_OP_REGS: begin
                in1_c_o = rs1_i;
                in2_c_o = rs2_i;
            end
            RISCV_ALU_OP_IMM: begin
                in1_c_o = rs1_i;
                in2_c_o = imm_i;
            end
            default: begin
                in1_c_o = '0;
                in2_c_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage (req 0)
// and the address/aux unit (req 1). Round-robin grant, one op per cycle, and a
// registered per-requester response slot with valid/ready handshake.
// Optional build macro ALU_ARB_STATS_EN adds grant/conflict counters.
//   clk, reset              clock, synchronous active-high reset
//   req_valid / req_ready   per-requester request handshake (ready = grant)
//   req_opcode..req_imm     per-requester instruction fields
//   alu_in1/alu_in2/alu_op  operands and op to the shared ALU
//   alu_result              combinational ALU result
//   rsp_valid/rsp_ready     per-requester response handshake
//   rsp_data                registered result per requester
//   grant_cnt0/1, conflict_cnt  (ALU_ARB_STATS_EN only) wrapping counters
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned OPW  = OPW_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][OPC_W-1:0]      req_opcode,
    input  logic [1:0][OPW-1:0]        req_alu_op,
    input  logic [1:0][XLEN-1:0]       req_rs1,
    input  logic [1:0][XLEN-1:0]       req_rs2,
    input  logic [1:0][XLEN-1:0]       req_pc,
    input  logic [1:0][XLEN-1:0]       req_imm,
    output logic [XLEN-1:0]            alu_in1,
    output logic [XLEN-1:0]            alu_in2,
    output logic [OPW-1:0]             alu_op,
    input  logic [XLEN-1:0]            alu_result,
    output logic [1:0]                 rsp_valid,
    input  logic [1:0]                 rsp_ready,
`ifdef ALU_ARB_STATS_EN
    output logic [31:0]                grant_cnt0,
    output logic [31:0]                grant_cnt1,
    output logic [31:0]                conflict_cnt,
`endif
    output logic [1:0][XLEN-1:0]       rsp_data
);

    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [1:0][XLEN-1:0]  rsp_data_q,  rsp_data_d;
    logic                  rr_ptr_q,    rr_ptr_d;

    logic [1:0]            eligible_c;
    logic [1:0]            grant_c;
    logic                  gnt_any_c;
    logic                  gnt_idx_c;
    logic [XLEN-1:0]       opsel_in1_c, opsel_in2_c;

    // Arbitration: a requester competes only if its slot is free or draining
    always_comb begin
        eligible_c = req_valid & (~rsp_valid_q | rsp_ready);
        grant_c    = 2'b00;
        if (!reset) begin
            if (&eligible_c) begin
                grant_c = rr_ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant_c = eligible_c;
            end
        end
        // Priority moves to the side that was not just served
        rr_ptr_d = rr_ptr_q;
        if (grant_c[0]) begin
            rr_ptr_d = 1'b1;
        end else if (grant_c[1]) begin
            rr_ptr_d = 1'b0;
        end
    end

    assign gnt_any_c = |grant_c;
    assign gnt_idx_c = grant_c[1];
    assign req_ready = grant_c;

    // Operand select on the granted requester's fields
    alu_operand_select #(
        .XLEN (XLEN)
    ) u_operand_select (
        .opcode_i (req_opcode[gnt_idx_c]),
        .rs1_i    (req_rs1[gnt_idx_c]),
        .rs2_i    (req_rs2[gnt_idx_c]),
        .pc_i     (req_pc[gnt_idx_c]),
        .imm_i    (req_imm[gnt_idx_c]),
        .in1_c_o  (opsel_in1_c),
        .in2_c_o  (opsel_in2_c)
    );

    assign alu_in1 = gnt_any_c ? opsel_in1_c : '0;
    assign alu_in2 = gnt_any_c ? opsel_in2_c : '0;
    assign alu_op  = gnt_any_c ? req_alu_op[gnt_idx_c] : '0;

    // Response slots: a new grant wins over a same-cycle drain
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < 2; i++) begin
            if (grant_c[i]) begin
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = alu_result;
            end else if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rr_ptr_q    <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q;
    logic        conflict_c;

    // Contention: both asked and exactly one was served
    assign conflict_c = (&req_valid) & gnt_any_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (grant_c[0]) grant_cnt0_q   <= grant_cnt0_q   + 32'd1;
            if (grant_c[1]) grant_cnt1_q   <= grant_cnt1_q   + 32'd1;
            if (conflict_c) conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized bench for alu_arbiter. A reference
// model predicts grants/operands each cycle and queues expected results; a
// separate monitor pops and compares responses as the DUT presents them.
// Honours ALU_ARB_STATS_EN to also check the statistics counters.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 4;
    localparam logic [6:0]  OPC_LOAD = 7'b0000011;

    logic                 clk;
    logic                 reset;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][6:0]      req_opcode;
    logic [1:0][OPW-1:0]  req_alu_op;
    logic [1:0][XLEN-1:0] req_rs1, req_rs2, req_pc, req_imm;
    logic [XLEN-1:0]      alu_in1, alu_in2, alu_result;
    logic [OPW-1:0]       alu_op;
    logic [1:0]           rsp_valid;
    logic [1:0]           rsp_ready;
    logic [1:0][XLEN-1:0] rsp_data;
    logic [31:0]          grant_cnt0, grant_cnt1, conflict_cnt;

    int tests = 0;
    int errs  = 0;
    int cyc   = 0;

    typedef struct { int tag; logic [31:0] data; } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int          last_gnt = 1;
    int unsigned m_g0 = 0, m_g1 = 0, m_cf = 0;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_alu_op (req_alu_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_pc     (req_pc),
        .req_imm    (req_imm),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
        .conflict_cnt (conflict_cnt),
`endif
        .rsp_data   (rsp_data)
    );

`ifndef ALU_ARB_STATS_EN
    assign grant_cnt0   = '0;
    assign grant_cnt1   = '0;
    assign conflict_cnt = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU feeding the DUT and the reference model
    function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_in1, alu_in2);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester rule: a pending request keeps valid and payload until granted
    assert property (@(posedge clk) disable iff (reset)
        (req_valid[0] && !req_ready[0]) |=> (req_valid[0] && $stable(req_opcode[0]) &&
        $stable(req_alu_op[0]) && $stable(req_rs1[0]) && $stable(req_rs2[0]) &&
        $stable(req_pc[0]) && $stable(req_imm[0])))
        else $error("requester 0 dropped or changed a pending request");
    assert property (@(posedge clk) disable iff (reset)
        (req_valid[1] && !req_ready[1]) |=> (req_valid[1] && $stable(req_opcode[1]) &&
        $stable(req_alu_op[1]) && $stable(req_rs1[1]) && $stable(req_rs2[1]) &&
        $stable(req_pc[1]) && $stable(req_imm[1])))
        else $error("requester 1 dropped or changed a pending request");

    // Reference model: a slot is busy while the scoreboard holds its result
    always @(negedge clk) begin : model
        logic [1:0]  elig, exp_gnt;
        logic [6:0]  opc;
        logic [31:0] e1, e2, r;
        logic [3:0]  eop;
        int          w;
        exp_t        ent;
        if (reset) begin
            q0.delete();
            q1.delete();
            last_gnt = 1;
            m_g0 = 0; m_g1 = 0; m_cf = 0;
            chk("reset_req_ready", 32'(req_ready), 32'd0);
            chk("reset_alu_in1", alu_in1, 32'd0);
            chk("reset_alu_in2", alu_in2, 32'd0);
        end else begin
            elig[0] = req_valid[0] && (q0.size() == 0 || rsp_ready[0]);
            elig[1] = req_valid[1] && (q1.size() == 0 || rsp_ready[1]);
            if (elig == 2'b11)  w = (last_gnt == 0) ? 1 : 0;
            else if (elig[0])   w = 0;
            else if (elig[1])   w = 1;
            else                w = -1;
            exp_gnt = 2'b00;
            e1 = '0; e2 = '0; eop = '0;
            if (w >= 0) begin
                exp_gnt[w] = 1'b1;
                opc = req_opcode[w];
                eop = req_alu_op[w];
                if (opc == RISCV_AUIPC) begin
                    e1 = req_pc[w];  e2 = req_imm[w];
                end else if (opc == RISCV_ALU_OP_REGS) begin
                    e1 = req_rs1[w]; e2 = req_rs2[w];
                end else if (opc == RISCV_ALU_OP_IMM) begin
                    e1 = req_rs1[w]; e2 = req_imm[w];
                end
                r = alu_f(eop, e1, e2);
                ent.tag  = cyc + 1;
                ent.data = r;
                if (w == 0) begin q0.push_back(ent); m_g0++; end
                else        begin q1.push_back(ent); m_g1++; end
                if (req_valid == 2'b11) m_cf++;
                last_gnt = w;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_gnt));
            chk("alu_in1", alu_in1, e1);
            chk("alu_in2", alu_in2, e2);
            chk("alu_op", 32'(alu_op), 32'(eop));
        end
    end

    task automatic mon_slot(int i);
        bit   has;
        exp_t f;
        has = 1'b0;
        if (i == 0 && q0.size() > 0 && q0[0].tag <= cyc) begin has = 1'b1; f = q0[0]; end
        if (i == 1 && q1.size() > 0 && q1[0].tag <= cyc) begin has = 1'b1; f = q1[0]; end
        chk($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(has));
        if (has) begin
            chk($sformatf("rsp_data%0d", i), rsp_data[i], f.data);
            if (rsp_ready[i]) begin
                if (i == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    // Monitor: compares whatever the response slots present
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            mon_slot(0);
            mon_slot(1);
        end
    end

    task automatic tick();
        logic [1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
    endtask

    task automatic set_req(int i, logic [6:0] opc, logic [3:0] aop, logic [31:0] rs1,
                           logic [31:0] rs2, logic [31:0] pc, logic [31:0] imm);
        req_opcode[i] = opc;
        req_alu_op[i] = aop;
        req_rs1[i]    = rs1;
        req_rs2[i]    = rs2;
        req_pc[i]     = pc;
        req_imm[i]    = imm;
        req_valid[i]  = 1'b1;
    endtask

    task automatic rand_req(int i);
        logic [6:0] opc;
        case ($urandom_range(0, 4))
            0:       opc = RISCV_AUIPC;
            1:       opc = RISCV_ALU_OP_REGS;
            2:       opc = RISCV_ALU_OP_IMM;
            3:       opc = OPC_LOAD;
            default: opc = 7'($urandom);
        endcase
        set_req(i, opc, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic drain();
        rsp_ready = 2'b11;
        for (int k = 0; k < 20 && req_valid != 2'b00; k++) tick();
        chk("drain_timeout", 32'(req_valid), 32'd0);
        tick();
    endtask

    initial begin
        int unsigned base_cf, base_g;
        reset      = 1'b1;
        req_valid  = '0;
        req_opcode = '0;
        req_alu_op = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_pc     = '0;
        req_imm    = '0;
        rsp_ready  = 2'b11;

        // Reset held with both requesters asking
        req_valid = 2'b11;
        tick();
        tick();
        reset     = 1'b0;
        req_valid = 2'b00;
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_reset_rsp_data0", rsp_data[0], 32'd0);
        chk("post_reset_rsp_data1", rsp_data[1], 32'd0);

        // Single OP-IMM add on requester 0
        set_req(0, RISCV_ALU_OP_IMM, ALU_ADD, 32'd5, 32'd99, 32'd0, 32'd7);
        #1;
        chk("opimm_in1", alu_in1, 32'd5);
        chk("opimm_in2", alu_in2, 32'd7);
        tick();
        chk("opimm_rsp_valid0", 32'(rsp_valid[0]), 32'd1);
        chk("opimm_rsp_data0", rsp_data[0], 32'd12);
        drain();

        // Both requesters saturating: grants alternate
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i]) set_req(i, RISCV_ALU_OP_REGS, ALU_ADD, $urandom, $urandom, 32'd0, 32'd0);
            end
            tick();
        end
        drain();

        // AUIPC on requester 1
        set_req(1, RISCV_AUIPC, ALU_ADD, $urandom, $urandom, 32'h1000, 32'h2000);
        #1;
        chk("auipc_in1", alu_in1, 32'h1000);
        chk("auipc_in2", alu_in2, 32'h2000);
        tick();
        chk("auipc_rsp_data1", rsp_data[1], 32'h3000);
        drain();

        // Back-pressure on slot 0 lets requester 1 through
        rsp_ready = 2'b10;
        set_req(0, RISCV_ALU_OP_REGS, ALU_SUB, 32'd50, 32'd8, 32'd0, 32'd0);
        #1;
        chk("bp_first_grant", 32'(req_ready), 32'd1);
        tick();
        set_req(0, RISCV_ALU_OP_REGS, ALU_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0);
        set_req(1, RISCV_ALU_OP_IMM, ALU_OR, 32'h10, 32'd0, 32'd0, 32'h01);
        #1;
        chk("bp_blocked_grant", 32'(req_ready), 32'd2);
        tick();
        rsp_ready[0] = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'd1);
        tick();
        drain();

        // Non-ALU opcode still granted, zero operands
        set_req(0, OPC_LOAD, ALU_ADD, 32'd3, 32'd4, 32'h40, 32'h8);
        #1;
        chk("load_in1", alu_in1, 32'd0);
        chk("load_in2", alu_in2, 32'd0);
        chk("load_grant", 32'(req_ready), 32'd1);
        tick();
        chk("load_rsp_valid0", 32'(rsp_valid[0]), 32'd1);
        drain();

        // Ten contended cycles
        base_cf = m_cf;
        base_g  = m_g0 + m_g1;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i]) rand_req(i);
            end
            tick();
        end
`ifdef ALU_ARB_STATS_EN
        chk("conflict_10", conflict_cnt - base_cf, 32'd10);
        chk("grants_10", (grant_cnt0 + grant_cnt1) - base_g, 32'd10);
`endif
        drain();

        // Randomized traffic with one mid-run reset
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                reset     = 1'b1;
                req_valid = 2'b00;
                tick();
                reset = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) != 0) rand_req(i);
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        drain();
        tick();

`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", grant_cnt0, m_g0);
        chk("grant_cnt1", grant_cnt1, m_g1);
        chk("conflict_cnt", conflict_cnt, m_cf);
`endif
        chk("final_q0_empty", 32'(q0.size()), 32'd0);
        chk("final_q1_empty", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
